// File: rtl/axis_packet_snooper.sv
// Passive AXI-Stream tap that copies each observed packet into packetmem and pulses done.
// Optional drop counter enabled by defining SNOOPER_DROP_COUNT_EN.
module axis_packet_snooper #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DROP_CNT_WIDTH       = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [63:0]                     s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [63:0]                     snooper_wr_data,
    output logic                            snooper_wr_en,
    output logic                            snooper_done,
    input  logic                            ready_for_snooper,
    input  logic                            drop_cnt_clear,
    output logic [DROP_CNT_WIDTH-1:0]       num_packets_dropped
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_DROP    = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [SNOOP_FWD_ADDR_WIDTH-1:0] ADDR_ZERO = SNOOP_FWD_ADDR_WIDTH'(1'b0);
    localparam logic [SNOOP_FWD_ADDR_WIDTH-1:0] ADDR_ONE  = SNOOP_FWD_ADDR_WIDTH'(1'b1);
    localparam logic [SNOOP_FWD_ADDR_WIDTH-1:0] ADDR_MAX  = {SNOOP_FWD_ADDR_WIDTH{1'b1}};

    logic [2:0]                      state_r;
    logic [2:0]                      state_s;
    logic                            sof_r;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] ptr_r;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] ptr_s;
    logic                            full_r;
    logic                            full_s;
    logic                            wr_en_s;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] wr_addr_s;
    logic                            drop_s;
    logic                            beat_s;
    logic                            start_s;

    logic                            wr_en_r;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] wr_addr_r;
    logic [63:0]                     wr_data_r;
    logic                            done_r;

    assign beat_s  = s_axis_tvalid & s_axis_tready;
    assign start_s = beat_s & sof_r;

    // Next-state, write-request and drop-event decode.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        full_s    = full_r;
        wr_en_s   = 1'b0;
        wr_addr_s = ptr_r;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (ready_for_snooper) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = ADDR_ZERO;
                        ptr_s     = ADDR_ONE;
                        full_s    = 1'b0;
                        state_s   = s_axis_tlast ? ST_FLUSH : ST_CAPTURE;
                    end else begin
                        drop_s  = 1'b1;
                        state_s = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (beat_s) begin
                    // Beats past the buffer end are swallowed; the address holds at its top.
                    if (!full_r) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = ptr_r;
                        if (ptr_r == ADDR_MAX) begin
                            full_s = 1'b1;
                        end else begin
                            ptr_s = ptr_r + ADDR_ONE;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    state_s = s_axis_tlast ? ST_FLUSH : ST_CAPTURE;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_DROP: begin
                if (beat_s && s_axis_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_FLUSH, ST_HOLD: begin
                // A packet starting before the VM had a chance to re-arm cannot be captured.
                if (start_s) begin
                    drop_s  = 1'b1;
                    state_s = s_axis_tlast ? ST_IDLE : ST_DROP;
                end else begin
                    state_s = (state_r == ST_FLUSH) ? ST_HOLD : ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, start-of-frame tracking and capture pointer.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r <= ST_IDLE;
            sof_r   <= 1'b1;
            ptr_r   <= ADDR_ZERO;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            full_r  <= full_s;
            if (beat_s) begin
                sof_r <= s_axis_tlast;
            end
        end
    end

    // Registered packetmem write port and completion pulse.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= ADDR_ZERO;
            wr_data_r <= 64'd0;
            done_r    <= 1'b0;
        end else begin
            wr_en_r <= wr_en_s;
            done_r  <= (state_r == ST_FLUSH);
            if (wr_en_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= s_axis_tdata;
            end
        end
    end

    assign snooper_wr_en   = wr_en_r;
    assign snooper_wr_addr = wr_addr_r;
    assign snooper_wr_data = wr_data_r;
    assign snooper_done    = done_r;

`ifdef SNOOPER_DROP_COUNT_EN
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ZERO = DROP_CNT_WIDTH'(1'b0);
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE  = DROP_CNT_WIDTH'(1'b1);
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX  = {DROP_CNT_WIDTH{1'b1}};

    logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

    // Saturating drop counter; a clear coinciding with a drop keeps that drop.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            drop_cnt_r <= CNT_ZERO;
        end else if (drop_cnt_clear) begin
            drop_cnt_r <= drop_s ? CNT_ONE : CNT_ZERO;
        end else if (drop_s && (drop_cnt_r != CNT_MAX)) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
    end

    assign num_packets_dropped = drop_cnt_r;
`else
    logic unused_s;

    assign unused_s            = drop_cnt_clear ^ drop_s;
    assign num_packets_dropped = DROP_CNT_WIDTH'(1'b0);
`endif

endmodule
